// File: rtl/mult_digit_sequencer.sv
// Sequential WIDTH x WIDTH unsigned multiplier that schedules 2-bit digit pairs onto an external 2x2 multiplier.
// Latency DIGITS^2 cycles from accept to out_valid; result is held in DONE until out_ready, input stalls meanwhile.
module mult_digit_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [1:0]           dig_a,
    output logic [1:0]           dig_b,
    input  logic [3:0]           dig_p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);
    localparam int DIGITS = WIDTH / 2;
    localparam int IW     = (DIGITS > 2) ? $clog2(DIGITS) : 1;
    localparam int PW     = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [IW-1:0]     i_q, i_d;
    logic [IW-1:0]     j_q, j_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     result_q, result_d;

    logic [IW:0]       sum_ij;
    logic [PW-1:0]     partial;
    logic              j_last;
    logic              i_last;

    // Weight of digit pair (i,j) is 4^(i+j); the sum needs one extra bit.
    assign sum_ij  = {1'b0, i_q} + {1'b0, j_q};
    assign partial = PW'(dig_p) << {sum_ij, 1'b0};
    assign j_last  = (j_q == IW'(DIGITS - 1));
    assign i_last  = (i_q == IW'(DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            i_q      <= i_d;
            j_q      <= j_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        i_d      = i_q;
        j_d      = j_q;
        acc_d    = acc_q;
        result_d = result_q;
        dig_a    = 2'b00;
        dig_b    = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                dig_a = a_q[{i_q, 1'b0} +: 2];
                dig_b = b_q[{j_q, 1'b0} +: 2];
                acc_d = acc_q + partial;
                if (j_last) begin
                    j_d = '0;
                    i_d = i_q + IW'(1);
                    if (i_last) begin
                        i_d      = '0;
                        result_d = acc_q + partial;
                        state_d  = S_DONE;
                    end
                end else begin
                    j_d = j_q + IW'(1);
                end
            end
            S_DONE: begin
                // Returning to IDLE first guarantees one idle cycle before the next capture.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_mult_digit_sequencer.sv
// Directed bench for mult_digit_sequencer: cycle-phase reference model checked every cycle plus literal results.
module tb_mult_digit_sequencer;
    localparam int WIDTH  = 8;
    localparam int DIGITS = WIDTH / 2;
    localparam int NRUN   = DIGITS * DIGITS;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   a = '0;
    logic [WIDTH-1:0]   b = '0;
    logic [1:0]         dig_a;
    logic [1:0]         dig_b;
    logic [3:0]         dig_p;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [2*WIDTH-1:0] result;
    logic               busy;

    int total = 0;
    int bad   = 0;

    mult_digit_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .dig_a     (dig_a),
        .dig_b     (dig_b),
        .dig_p     (dig_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    // External 2x2 combinational multiplier.
    assign dig_p = {2'b00, dig_a} * {2'b00, dig_b};

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: phase 0 = idle, 1..NRUN = run step (phase-1), NRUN+1 = done.
    int          m_phase = 0;
    int unsigned m_a = 0;
    int unsigned m_b = 0;
    int unsigned m_res = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_a     = 0;
            m_b     = 0;
            m_res   = 0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_a     = a;
                m_b     = b;
                m_phase = 1;
            end
        end else if (m_phase <= NRUN) begin
            if (m_phase == NRUN) m_res = m_a * m_b;
            m_phase = m_phase + 1;
        end else if (out_ready) begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        int k;
        int unsigned ea;
        int unsigned eb;
        ea = 0;
        eb = 0;
        if (m_phase >= 1 && m_phase <= NRUN) begin
            k  = m_phase - 1;
            ea = (m_a >> (2 * (k / DIGITS))) & 3;
            eb = (m_b >> (2 * (k % DIGITS))) & 3;
        end
        chk("in_ready",  32'(in_ready),  32'(m_phase == 0));
        chk("busy",      32'(busy),      32'(m_phase != 0));
        chk("out_valid", 32'(out_valid), 32'(m_phase == NRUN + 1));
        chk("dig_a",     32'(dig_a),     ea);
        chk("dig_b",     32'(dig_b),     eb);
        chk("result",    32'(result),    m_res);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a pair with in_valid for exactly the accepting edge (DUT is assumed idle).
    task automatic accept(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Edges from the current point until out_valid is seen, bounded.
    task automatic wait_valid(input string nm, output int n);
        n = 1;
        while (!out_valid && n < 200) begin
            step();
            if (!out_valid) n++;
        end
        if (!out_valid) chk({nm, "_timeout"}, 0, 1);
    endtask

    initial begin
        int n;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        rst_n = 1'b1;

        // All-ones operands: latency and full-width product.
        accept(8'hFF, 8'hFF);
        wait_valid("ff", n);
        chk("ff_latency", n, NRUN);
        chk("ff_result", 32'(result), 32'hFE01);
        step();
        chk("ff_idle", 32'(busy), 32'h0);

        // First scheduled digit pair and mixed digits.
        a = 8'h0D; b = 8'hB3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("0d_first_dig_a", 32'(dig_a), 32'h1);
        chk("0d_first_dig_b", 32'(dig_b), 32'h3);
        step();
        chk("0d_second_dig_b", 32'(dig_b), 32'h0);
        wait_valid("0d", n);
        chk("0d_result", 32'(result), 32'h0917);
        step();

        // Zero operand still runs the whole schedule: busy for RUN + one DONE cycle.
        accept(8'h00, 8'hFF);
        n = 0;
        while (busy && n < 200) begin
            n++;
            step();
        end
        chk("zero_busy_cycles", n, NRUN + 1);
        chk("zero_result", 32'(result), 32'h0);

        // Back-pressure in DONE with stray in_valid pulses.
        out_ready = 1'b0;
        accept(8'h5A, 8'hC3);
        wait_valid("bp", n);
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            a = 8'h11; b = 8'h22;
            step();
            chk("bp_out_valid", 32'(out_valid), 32'h1);
            chk("bp_result", 32'(result), 32'h448E);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_released", 32'(out_valid), 32'h0);

        // Reset during RUN cycle 7 aborts; the next pair runs cleanly.
        accept(8'hAB, 8'hCD);
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'h1);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_dig_a", 32'(dig_a), 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        accept(8'h12, 8'h34);
        wait_valid("post_rst", n);
        chk("post_rst_latency", n, NRUN);
        chk("post_rst_result", 32'(result), 32'h03A8);
        step();

        // Back-to-back with in_valid held high.
        a = 8'h21; b = 8'h0F; in_valid = 1'b1;
        step();
        a = 8'h9C; b = 8'h47;
        wait_valid("b2b1", n);
        chk("b2b1_result", 32'(result), 32'h01EF);
        step();
        chk("b2b_gap_idle", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        chk("b2b2_accepted", 32'(busy), 32'h1);
        wait_valid("b2b2", n);
        chk("b2b2_result", 32'(result), 32'h2B44);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t: got running expected finished", $time);
        $fatal(1, "timeout");
    end

endmodule
